// File: rtl/sw_ctrl_pkg.sv
// sw_ctrl_pkg: state encodings and set-field codes shared by the stopwatch/watch controller
package sw_ctrl_pkg;
   localparam logic [1:0] SW_STOP    = 2'd0;
   localparam logic [1:0] SW_RUN     = 2'd1;
   localparam logic [1:0] SW_CLEAR   = 2'd2;
   localparam logic [1:0] W_NORMAL   = 2'd0;
   localparam logic [1:0] W_SET_HOUR = 2'd1;
   localparam logic [1:0] W_SET_MIN  = 2'd2;
   localparam logic [1:0] W_SET_SEC  = 2'd3;
   localparam logic [1:0] FIELD_NONE = 2'd0;
   localparam logic [1:0] FIELD_HOUR = 2'd1;
   localparam logic [1:0] FIELD_MIN  = 2'd2;
   localparam logic [1:0] FIELD_SEC  = 2'd3;
   function automatic logic [1:0] field_of(input logic [1:0] w);
      return w == W_SET_HOUR ? FIELD_HOUR :
             w == W_SET_MIN  ? FIELD_MIN  :
             w == W_SET_SEC  ? FIELD_SEC  : FIELD_NONE;
   endfunction
   function automatic logic [1:0] w_after_r(input logic [1:0] w);
      return w == W_NORMAL   ? W_SET_HOUR :
             w == W_SET_HOUR ? W_SET_MIN  :
             w == W_SET_MIN  ? W_SET_SEC  : W_NORMAL;
   endfunction
endpackage

// File: rtl/set_timeout_cnt.sv
// set_timeout_cnt: saturating idle counter that flags when set mode has been idle too long
// Ports: clk, rst (async active-low), clear (zero the count), enable (count this cycle),
//        expired (count has reached TIMEOUT_CYC-1)
module set_timeout_cnt #(
   parameter int TIMEOUT_CYC = 500_000_000,
   parameter int TW          = $clog2(TIMEOUT_CYC)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   logic [TW-1:0] cnt;
   assign expired = (cnt == TW'(TIMEOUT_CYC - 1));
   // Saturates at the terminal value so it can never wrap back to zero
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else if (clear) cnt <= '0;
      else if (enable && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/sw_watch_ctrl.sv
// sw_watch_ctrl: button-driven control of a stopwatch and a settable watch
// Ports: clk, rst (async active-low); i_btn_l/r/d one-cycle button pulses (MODE, RUN/SET, CLEAR/INC);
//        o_disp_sel (1 = watch shown), o_sw_run, o_sw_clear pulse, o_set_field, o_inc pulse, o_watch_hold
module sw_watch_ctrl
   import sw_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = 500_000_000,
   parameter int TW          = $clog2(TIMEOUT_CYC)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_btn_l,
   input  logic       i_btn_r,
   input  logic       i_btn_d,
   output logic       o_disp_sel,
   output logic       o_sw_run,
   output logic       o_sw_clear,
   output logic [1:0] o_set_field,
   output logic       o_inc,
   output logic       o_watch_hold
);
   logic [1:0] sw_st, sw_nxt, w_st, w_nxt;
   logic       acc_r, acc_d, sw_r, sw_d, w_r, w_d, inc_nxt, expired, tmr_clear;
   always_comb begin
      // Fixed priority l > r > d: losers are simply dropped
      acc_r = i_btn_r & ~i_btn_l;
      acc_d = i_btn_d & ~i_btn_l & ~i_btn_r;
      // r/d only reach the FSM whose function is on the display
      sw_r = acc_r & ~o_disp_sel;
      sw_d = acc_d & ~o_disp_sel;
      w_r  = acc_r & o_disp_sel;
      w_d  = acc_d & o_disp_sel;
      sw_nxt = sw_st == SW_CLEAR ? SW_STOP :
               sw_st == SW_RUN   ? (sw_r ? SW_STOP : SW_RUN) :
               sw_r ? SW_RUN : sw_d ? SW_CLEAR : SW_STOP;
      // A d pulse in the expiry cycle keeps the set state alive; timeout only wins when idle
      w_nxt = i_btn_l ? W_NORMAL :
              w_r ? w_after_r(w_st) :
              (expired && w_st != W_NORMAL && !w_d) ? W_NORMAL : w_st;
      inc_nxt   = w_d && (w_st != W_NORMAL);
      tmr_clear = (w_nxt == W_NORMAL) | w_r | w_d;
   end
   set_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC), .TW(TW)) u_tmr (
      .clk    (clk),
      .rst    (rst),
      .clear  (tmr_clear),
      .enable (w_st != W_NORMAL),
      .expired(expired)
   );
   // Outputs are registered from next-state so they line up with the state change
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         sw_st        <= SW_STOP;
         w_st         <= W_NORMAL;
         o_disp_sel   <= 1'b0;
         o_sw_run     <= 1'b0;
         o_sw_clear   <= 1'b0;
         o_set_field  <= FIELD_NONE;
         o_inc        <= 1'b0;
         o_watch_hold <= 1'b0;
      end else begin
         sw_st        <= sw_nxt;
         w_st         <= w_nxt;
         o_disp_sel   <= o_disp_sel ^ i_btn_l;
         o_sw_run     <= (sw_nxt == SW_RUN);
         o_sw_clear   <= (sw_nxt == SW_CLEAR);
         o_set_field  <= field_of(w_nxt);
         o_inc        <= inc_nxt;
         o_watch_hold <= (w_nxt != W_NORMAL);
      end
endmodule

// File: doc/sw_watch_ctrl.md
SW_WATCH_CTRL -- requirements
Module: sw_watch_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYC, 500_000_000, idle clk cycles before set mode auto-exits (5 s at 100 MHz).
REQ-002 Parameter: TW, $clog2(TIMEOUT_CYC), width of the idle counter.
REQ-003 Port: clk  in  1  system clock, 100 MHz; one clock domain only.
REQ-004 Port: rst  in  1  reset, asynchronous, active-low.
REQ-005 Port: i_btn_l  in  1  debounced 1-cycle pulse, MODE button.
REQ-006 Port: i_btn_r  in  1  debounced 1-cycle pulse, RUN/SET button.
REQ-007 Port: i_btn_d  in  1  debounced 1-cycle pulse, CLEAR/INC button.
REQ-008 Port: o_disp_sel  out  1  0 = stopwatch shown, 1 = watch shown.
REQ-009 Port: o_sw_run  out  1  level, stopwatch counting enabled.
REQ-010 Port: o_sw_clear  out  1  1-cycle pulse, clear stopwatch count.
REQ-011 Port: o_set_field  out  2  0 none, 1 hour, 2 min, 3 sec.
REQ-012 Port: o_inc  out  1  1-cycle pulse, increment field named by o_set_field.
REQ-013 Port: o_watch_hold  out  1  high while o_set_field != 0; freezes watch seconds tick.

Function
REQ-014 All outputs SHALL be registered; response to an input pulse appears exactly 1 clk after the pulse cycle.
REQ-015 Simultaneous pulses SHALL be arbitrated by fixed priority l > r > d; only the winner is accepted, losers are dropped, not queued.
REQ-016 Accepted i_btn_l SHALL toggle o_disp_sel; if watch FSM is in a SET state it SHALL return to W_NORMAL in the same update.
REQ-017 i_btn_r and i_btn_d SHALL be routed only to the FSM of the currently displayed function; the other FSM ignores them.
REQ-018 Stopwatch FSM states SW_STOP, SW_RUN, SW_CLEAR; o_sw_run = 1 only in SW_RUN.
REQ-019 SW_STOP: r -> SW_RUN; d -> SW_CLEAR. SW_RUN: r -> SW_STOP; d ignored. SW_CLEAR: unconditional -> SW_STOP after 1 cycle; any pulse during SW_CLEAR is dropped.
REQ-020 o_sw_clear SHALL be 1 for exactly the one cycle the FSM is in SW_CLEAR.
REQ-021 Stopwatch FSM SHALL keep its state (including running) while the watch is displayed.
REQ-022 Watch FSM states W_NORMAL, W_SET_HOUR, W_SET_MIN, W_SET_SEC; o_set_field = 0,1,2,3 respectively.
REQ-023 r cycles W_NORMAL -> W_SET_HOUR -> W_SET_MIN -> W_SET_SEC -> W_NORMAL (wrap).
REQ-024 d in a SET state SHALL produce one o_inc pulse; d in W_NORMAL SHALL be ignored.
REQ-025 Idle counter SHALL clear on entering any SET state and on every accepted r/d pulse; increments each cycle while in a SET state.
REQ-026 Idle counter reaching TIMEOUT_CYC-1 SHALL force W_NORMAL next cycle; an accepted pulse in that same cycle SHALL take precedence over timeout.
REQ-027 Idle counter SHALL hold 0 in W_NORMAL; it SHALL never wrap.

Reset
REQ-028 On rst = 0: SW_STOP, W_NORMAL, o_disp_sel = 0, o_sw_run = 0, o_sw_clear = 0, o_set_field = 0, o_inc = 0, o_watch_hold = 0, idle counter = 0.
REQ-029 Reset asserted mid-operation (e.g. SW_RUN or W_SET_MIN) SHALL force reset values immediately, independent of clk; no pulse SHALL be emitted on release.

Structure
REQ-030 Shared package sw_ctrl_pkg SHALL hold stopwatch and watch state encodings and the o_set_field codes (FIELD_NONE/HOUR/MIN/SEC).
REQ-031 Idle timer SHALL be one sub-module set_timeout_cnt (inputs clear, enable; output expired); both FSMs stay in sw_watch_ctrl.

Verification (TIMEOUT_CYC = 20)
REQ-032 r pulse in stopwatch view -> o_sw_run = 1 next cycle; second r -> o_sw_run = 0.
REQ-033 SW_STOP, d pulse -> o_sw_clear high exactly 1 cycle, o_sw_run stays 0; d during SW_RUN -> no o_sw_clear.
REQ-034 l, r, d pulsed in the same cycle -> only o_disp_sel toggles; o_sw_run and o_inc unchanged.
REQ-035 Watch view: r, d, d -> o_set_field = 1 with two o_inc pulses; r x3 more -> o_set_field = 2, 3, 0.
REQ-036 W_SET_MIN, no pulses for 20 cycles -> o_set_field = 0, o_watch_hold = 0 exactly on cycle 20; d at cycle 19 -> timeout restarts.
REQ-037 Stopwatch running, l to watch, r to W_SET_HOUR, rst low 3 cycles -> all outputs at reset values, o_sw_run = 0 after release.
